// File: rtl/jump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jump_pkg
// Purpose  : Shared state encoding, default widths and saturating adder for
//            the jump trajectory generator and its controlling FSM.
// Revision : 1.0
// ============================================================================
package jump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLIGHT = 2'd1,
        ST_DONE   = 2'd2
    } jump_state_t;

    localparam int V_W_DEFAULT = 11;
    localparam int H_W_DEFAULT = 9;
    localparam int D_W_DEFAULT = 11;
    localparam int T_W_DEFAULT = 8;

    // Unsigned add clamped at max_val; a 33-bit sum keeps the carry visible.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max_val
    );
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/jump_trajectory_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : jump_trajectory_gen_if
// Purpose  : Enable/velocity request and trajectory result bundle between the
//            jump FSM (master) and the trajectory generator (slave).
// Revision : 1.0
// ============================================================================
interface jump_trajectory_gen_if #(
    parameter int V_W = jump_pkg::V_W_DEFAULT,
    parameter int H_W = jump_pkg::H_W_DEFAULT,
    parameter int D_W = jump_pkg::D_W_DEFAULT,
    parameter int T_W = jump_pkg::T_W_DEFAULT
) ();

    logic           i_en;
    logic [V_W-1:0] i_v_init;
    logic [H_W-1:0] o_height;
    logic [D_W-1:0] o_dist;
    logic [T_W-1:0] o_ticks;
    logic           o_busy;
    logic           o_apex;
    logic           o_done;

    modport master (
        output i_en,
        output i_v_init,
        input  o_height,
        input  o_dist,
        input  o_ticks,
        input  o_busy,
        input  o_apex,
        input  o_done
    );

    modport slave (
        input  i_en,
        input  i_v_init,
        output o_height,
        output o_dist,
        output o_ticks,
        output o_busy,
        output o_apex,
        output o_done
    );

endinterface
`default_nettype wire

// File: rtl/jump_trajectory_gen_tick_edge.sv
`default_nettype none
// ============================================================================
// Module   : tick_edge
// Purpose  : Synchronises the divided-clock bit and emits a one-cycle pulse
//            per rising edge.
// Revision : 1.0
// ============================================================================
module tick_edge (
    input  wire logic clk_machine,
    input  wire logic rst_machine,
    input  wire logic i_tick_src,
    output logic      o_tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync2_d;

    always_ff @(posedge clk_machine or posedge rst_machine) begin
        if (rst_machine) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync2_d <= 1'b0;
        end else begin
            r_sync1   <= i_tick_src;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
        end
    end

    assign o_tick = r_sync2 & ~r_sync2_d;

endmodule
`default_nettype wire

// File: rtl/jump_trajectory_gen.sv
`default_nettype none
// ============================================================================
// Module   : jump_trajectory_gen
// Purpose  : Ballistic jump integrator (height, distance, airtime) stepped by
//            rising edges of a slow divided-clock bit.
// Revision : 1.0
// ============================================================================
module jump_trajectory_gen
    import jump_pkg::*;
#(
    parameter int V_W     = V_W_DEFAULT,
    parameter int H_W     = H_W_DEFAULT,
    parameter int D_W     = D_W_DEFAULT,
    parameter int GRAVITY = 1,
    parameter int VX_STEP = 1,
    parameter int T_W     = T_W_DEFAULT
) (
    input  wire logic            clk_machine,
    input  wire logic            rst_machine,
    input  wire logic            i_tick_src,
    jump_trajectory_gen_if.slave bus
);

    localparam int                      S_W       = ((H_W > V_W) ? H_W : V_W) + 2;
    localparam logic signed [V_W+1:0]   C_GRAVITY = (V_W+2)'(GRAVITY);
    localparam logic signed [S_W-1:0]   C_H_MAX   = S_W'({H_W{1'b1}});
    localparam logic [31:0]             C_D_MAX   = 32'({D_W{1'b1}});
    localparam logic [31:0]             C_T_MAX   = 32'({T_W{1'b1}});
    localparam logic [31:0]             C_VX_STEP = 32'(VX_STEP);

    jump_state_t              r_state;
    jump_state_t              w_state_next;
    logic [H_W-1:0]           r_h;
    logic [H_W-1:0]           w_h_next;
    logic signed [V_W+1:0]    r_v;
    logic signed [V_W+1:0]    w_v_next;
    logic signed [V_W+1:0]    w_v_dec;
    logic [D_W-1:0]           r_d;
    logic [D_W-1:0]           w_d_next;
    logic [T_W-1:0]           r_t;
    logic [T_W-1:0]           w_t_next;
    logic                     r_apex;
    logic                     w_apex_next;
    logic                     w_tick;
    logic signed [S_W-1:0]    w_h_sum;
    logic                     w_land;
    logic                     w_apex_hit;

    tick_edge u_tick_edge (
        .clk_machine (clk_machine),
        .rst_machine (rst_machine),
        .i_tick_src  (i_tick_src),
        .o_tick      (w_tick)
    );

    // Height is unsigned; widen with zeros, velocity with its sign.
    assign w_h_sum    = $signed(S_W'(r_h)) + S_W'(r_v);
    assign w_v_dec    = r_v - C_GRAVITY;
    assign w_land     = w_h_sum[S_W-1] || (w_h_sum == '0);
    assign w_apex_hit = (!r_v[V_W+1] && (r_v != '0))
                     && (w_v_dec[V_W+1] || (w_v_dec == '0));

    always_ff @(posedge clk_machine or posedge rst_machine) begin
        if (rst_machine) begin
            r_state <= ST_IDLE;
            r_h     <= '0;
            r_v     <= '0;
            r_d     <= '0;
            r_t     <= '0;
            r_apex  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_h     <= w_h_next;
            r_v     <= w_v_next;
            r_d     <= w_d_next;
            r_t     <= w_t_next;
            r_apex  <= w_apex_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_h_next     = r_h;
        w_v_next     = r_v;
        w_d_next     = r_d;
        w_t_next     = r_t;
        w_apex_next  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_h_next = '0;
                w_d_next = '0;
                w_t_next = '0;
                // Any tick coinciding with the load cycle is deliberately dropped.
                if (bus.i_en) begin
                    w_v_next     = {2'b00, bus.i_v_init};
                    w_state_next = ST_FLIGHT;
                end
            end

            ST_FLIGHT: begin
                if (!bus.i_en) begin
                    w_h_next     = '0;
                    w_d_next     = '0;
                    w_t_next     = '0;
                    w_state_next = ST_IDLE;
                end else if (w_tick) begin
                    w_v_next    = w_v_dec;
                    w_d_next    = D_W'(sat_add(32'(r_d), C_VX_STEP, C_D_MAX));
                    w_t_next    = T_W'(sat_add(32'(r_t), 32'd1, C_T_MAX));
                    w_apex_next = w_apex_hit;
                    if (w_land) begin
                        w_h_next     = '0;
                        w_state_next = ST_DONE;
                    end else if (w_h_sum > C_H_MAX) begin
                        w_h_next = {H_W{1'b1}};
                    end else begin
                        w_h_next = w_h_sum[H_W-1:0];
                    end
                end
            end

            ST_DONE: begin
                w_h_next = '0;
                if (!bus.i_en) begin
                    w_d_next     = '0;
                    w_t_next     = '0;
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_h_next     = '0;
                w_d_next     = '0;
                w_t_next     = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.o_height = r_h;
    assign bus.o_dist   = r_d;
    assign bus.o_ticks  = r_t;
    assign bus.o_busy   = (r_state == ST_FLIGHT);
    assign bus.o_apex   = r_apex;
    assign bus.o_done   = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_jump_trajectory_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_jump_trajectory_gen
// Purpose  : Drives two differently sized generators with shared stimulus and
//            compares them against a tick-level ballistic model.
// Revision : 1.0
// ============================================================================
module tb_jump_trajectory_gen;

    localparam int P_IDLE   = 0;
    localparam int P_FLIGHT = 1;
    localparam int P_DONE   = 2;

    logic        clk_machine = 1'b0;
    logic        rst_machine;
    logic        i_tick_src;
    logic        r_en;
    logic [10:0] r_v_init;

    int n_checks = 0;
    int n_fail   = 0;

    int     m_phase[2];
    longint m_h[2];
    longint m_v[2];
    longint m_d[2];
    longint m_t[2];
    int     m_apex[2];
    int     apex_seen[2] = '{0, 0};

    jump_trajectory_gen_if #(.V_W(11), .H_W(9), .D_W(11), .T_W(8)) bus_a ();
    jump_trajectory_gen_if #(.V_W(11), .H_W(4), .D_W(3),  .T_W(8)) bus_b ();

    assign bus_a.i_en     = r_en;
    assign bus_a.i_v_init = r_v_init;
    assign bus_b.i_en     = r_en;
    assign bus_b.i_v_init = r_v_init;

    jump_trajectory_gen #(
        .V_W(11), .H_W(9), .D_W(11), .GRAVITY(1), .VX_STEP(1), .T_W(8)
    ) u_dut_a (
        .clk_machine (clk_machine),
        .rst_machine (rst_machine),
        .i_tick_src  (i_tick_src),
        .bus         (bus_a)
    );

    jump_trajectory_gen #(
        .V_W(11), .H_W(4), .D_W(3), .GRAVITY(1), .VX_STEP(3), .T_W(8)
    ) u_dut_b (
        .clk_machine (clk_machine),
        .rst_machine (rst_machine),
        .i_tick_src  (i_tick_src),
        .bus         (bus_b)
    );

    always #5 clk_machine = ~clk_machine;

    always @(negedge clk_machine) begin
        if (bus_a.o_apex === 1'b1) apex_seen[0]++;
        if (bus_b.o_apex === 1'b1) apex_seen[1]++;
    end

    function automatic longint h_max(input int i);
        return (i == 0) ? 511 : 15;
    endfunction

    function automatic longint d_max(input int i);
        return (i == 0) ? 2047 : 7;
    endfunction

    function automatic longint vx(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_machine);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = P_IDLE;
            m_h[i] = 0;
            m_d[i] = 0;
            m_t[i] = 0;
        end
    endtask

    task automatic model_load(input longint v0);
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = P_FLIGHT;
            m_h[i] = 0;
            m_d[i] = 0;
            m_t[i] = 0;
            m_v[i] = v0;
        end
    endtask

    // One physics tick: integrate, clamp, and land once height reaches the block.
    task automatic model_tick();
        longint hs;
        longint vn;
        for (int i = 0; i < 2; i++) begin
            if (m_phase[i] == P_FLIGHT) begin
                hs = m_h[i] + m_v[i];
                vn = m_v[i] - 1;
                if (m_v[i] > 0 && vn <= 0) m_apex[i]++;
                m_d[i] = (m_d[i] + vx(i) > d_max(i)) ? d_max(i) : m_d[i] + vx(i);
                m_t[i] = (m_t[i] + 1 > 255) ? 255 : m_t[i] + 1;
                m_v[i] = vn;
                if (hs <= 0) begin
                    m_h[i]     = 0;
                    m_phase[i] = P_DONE;
                end else begin
                    m_h[i] = (hs > h_max(i)) ? h_max(i) : hs;
                end
            end
        end
    endtask

    task automatic check_dut(input int i);
        logic [63:0] h, d, t;
        logic        busy, done;
        if (i == 0) begin
            h = 64'(bus_a.o_height); d = 64'(bus_a.o_dist); t = 64'(bus_a.o_ticks);
            busy = bus_a.o_busy; done = bus_a.o_done;
        end else begin
            h = 64'(bus_b.o_height); d = 64'(bus_b.o_dist); t = 64'(bus_b.o_ticks);
            busy = bus_b.o_busy; done = bus_b.o_done;
        end
        check($sformatf("dut%0d_height", i), h, 64'(m_h[i]));
        check($sformatf("dut%0d_dist", i), d, 64'(m_d[i]));
        check($sformatf("dut%0d_ticks", i), t, 64'(m_t[i]));
        check($sformatf("dut%0d_busy", i), 64'(busy), 64'(m_phase[i] == P_FLIGHT));
        check($sformatf("dut%0d_done", i), 64'(done), 64'(m_phase[i] == P_DONE));
        check($sformatf("dut%0d_apex_count", i), 64'(apex_seen[i]), 64'(m_apex[i]));
    endtask

    task automatic check_all();
        check_dut(0);
        check_dut(1);
    endtask

    // Optionally line the first synchronised edge up with the load cycle.
    task automatic start_jump(input int v0, input bit load_tick);
        r_v_init = 11'(v0);
        if (load_tick) begin
            i_tick_src = 1'b1;
            wait_cycles(2);
            r_en = 1'b1;
            wait_cycles(4);
            i_tick_src = 1'b0;
            wait_cycles(6);
        end else begin
            r_en = 1'b1;
            wait_cycles(2);
        end
        model_load(longint'(v0));
        check_all();
    endtask

    task automatic tick_pulse(input int hold, input int low);
        i_tick_src = 1'b1;
        wait_cycles(hold);
        i_tick_src = 1'b0;
        wait_cycles(low);
        model_tick();
        check_all();
    endtask

    task automatic drop_en();
        r_en = 1'b0;
        wait_cycles(1);
        model_clear();
        check_all();
    endtask

    initial begin
        int h3[7];
        int apex_base;
        int v0;
        int n;
        h3 = '{3, 5, 6, 6, 5, 3, 0};
        m_apex = '{0, 0};

        rst_machine = 1'b1;
        i_tick_src  = 1'b0;
        r_en        = 1'b0;
        r_v_init    = '0;
        wait_cycles(3);
        rst_machine = 1'b0;
        wait_cycles(2);
        model_clear();
        check_all();

        // Reference jump with v_init=3
        apex_base = apex_seen[0];
        start_jump(3, 1'b0);
        for (int k = 0; k < 7; k++) begin
            tick_pulse(6, 6);
            check($sformatf("v3_height_tick%0d", k + 1), 64'(bus_a.o_height), 64'(h3[k]));
            check($sformatf("v3_apex_tick%0d", k + 1), 64'(apex_seen[0] - apex_base),
                  64'((k >= 2) ? 1 : 0));
        end
        check("v3_done", 64'(bus_a.o_done), 64'd1);
        check("v3_dist", 64'(bus_a.o_dist), 64'd7);
        check("v3_ticks", 64'(bus_a.o_ticks), 64'd7);
        tick_pulse(6, 6);
        drop_en();
        check("v3_done_dropped", 64'(bus_a.o_done), 64'd0);

        // Zero launch velocity lands on the first tick
        apex_base = apex_seen[0];
        start_jump(0, 1'b0);
        tick_pulse(5, 6);
        check("v0_done", 64'(bus_a.o_done), 64'd1);
        check("v0_dist", 64'(bus_a.o_dist), 64'd1);
        check("v0_ticks", 64'(bus_a.o_ticks), 64'd1);
        check("v0_height", 64'(bus_a.o_height), 64'd0);
        check("v0_no_apex", 64'(apex_seen[0] - apex_base), 64'd0);
        drop_en();

        // Abort after two ticks
        start_jump(3, 1'b0);
        tick_pulse(4, 6);
        tick_pulse(4, 6);
        drop_en();
        check("abort_done_low", 64'(bus_a.o_done), 64'd0);

        // Saturation on the narrow instance
        start_jump(10, 1'b0);
        for (int k = 0; k < 3; k++) tick_pulse(4, 5);
        check("sat_height_narrow", 64'(bus_b.o_height), 64'd15);
        check("sat_dist_narrow", 64'(bus_b.o_dist), 64'd7);
        drop_en();

        // Tick in the load cycle, then long-held source levels
        start_jump(5, 1'b1);
        check("load_tick_height", 64'(bus_a.o_height), 64'd0);
        tick_pulse(40, 6);
        tick_pulse(25, 5);
        drop_en();

        // Asynchronous reset mid-flight
        start_jump(7, 1'b0);
        tick_pulse(4, 6);
        tick_pulse(4, 6);
        #1 rst_machine = 1'b1;
        #2;
        model_clear();
        check_all();
        r_en = 1'b0;
        #8 rst_machine = 1'b0;
        wait_cycles(2);
        check_all();

        // Randomised jumps, some landing, some aborted
        repeat (14) begin
            v0 = int'($urandom_range(0, 40));
            n  = int'($urandom_range(1, 2 * v0 + 4));
            start_jump(v0, ($urandom_range(0, 3) == 0));
            repeat (n) tick_pulse(int'($urandom_range(1, 20)), int'($urandom_range(4, 10)));
            wait_cycles(int'($urandom_range(0, 5)));
            check_all();
            drop_en();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
